// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: states, exception causes,
// instruction fields, ALU class codes and PC source selects.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_RST,
    ST_IF,
    ST_ID,
    ST_EXE_R,
    ST_EXE_B,
    ST_EXE_J,
    ST_EXE_M,
    ST_MEM,
    ST_WB_R,
    ST_WB_M,
    ST_EXC
  } state_t;

  localparam logic [1:0] CAUSE_IRQ = 2'd0;
  localparam logic [1:0] CAUSE_OVF = 2'd1;
  localparam logic [1:0] CAUSE_TMO = 2'd2;
  localparam logic [1:0] CAUSE_RSV = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [2:0] PCS_INC = 3'b000;
  localparam logic [2:0] PCS_BR  = 3'b001;
  localparam logic [2:0] PCS_JMP = 3'b010;
  localparam logic [2:0] PCS_REG = 3'b011;
  localparam logic [2:0] PCS_EXC = 3'b100;

  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
           (op == OP_SLTIU) || (op == OP_ANDI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive memory wait cycles in a waiting state and flags a timeout
// once the count has reached MEM_TIMEOUT (never when MEM_TIMEOUT is 0).
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_ready,
  input  logic i_state_chg,
  output logic o_timeout_c
);

  localparam int unsigned CNT_MAX = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT : 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_clear;

  assign w_clear = !i_active || i_ready || i_state_chg;

  // Saturating count so a disabled timeout never wraps into a false hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_W'(CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_timeout_c = (MEM_TIMEOUT != 0) && i_active && (r_cnt == CNT_W'(CNT_MAX));

endmodule

// File: rtl/mc_controller_hs.sv
// Multi-cycle MIPS-style control FSM with memory handshake, wait timeout,
// overflow / reserved-instruction / interrupt exceptions.
module mc_controller_hs
  import mc_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned IRQ_EN      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               overflow,
  input  logic               mem_ready,
  input  logic               irq,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               EPCWrite,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         RegDst,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         Cause
);

  state_t     r_state, w_next;
  logic [1:0] r_cause, w_exc_cause;
  logic       w_end, w_timeout, w_irq;
  logic       w_rtype, w_rtype_alu, w_itype, w_jr, w_jalr, w_jal, w_j, w_beq;
  logic       w_lw, w_sw, w_shift, w_ovf_op;
  logic [1:0] w_srca, w_srcb;
  logic [2:0] w_cls;

  function automatic logic [ALUOP_W-1:0] mk_aluop(input logic msb, input logic [2:0] cls);
    logic [ALUOP_W-1:0] v;
    v            = '0;
    v[ALUOP_W-1] = msb;
    v[2:0]       = cls;
    return v;
  endfunction

  assign w_irq       = (IRQ_EN != 0) ? irq : 1'b0;
  assign w_rtype     = (OpCode == OP_RTYPE);
  assign w_jr        = w_rtype && (Funct == FN_JR);
  assign w_jalr      = w_rtype && (Funct == FN_JALR);
  assign w_rtype_alu = w_rtype && !w_jr && !w_jalr;
  assign w_itype     = is_itype(OpCode);
  assign w_j         = (OpCode == OP_J);
  assign w_jal       = (OpCode == OP_JAL);
  assign w_beq       = (OpCode == OP_BEQ);
  assign w_lw        = (OpCode == OP_LW);
  assign w_sw        = (OpCode == OP_SW);
  assign w_shift     = w_rtype_alu &&
                       ((Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA));
  assign w_ovf_op    = (w_rtype && ((Funct == FN_ADD) || (Funct == FN_SUB))) ||
                       (OpCode == OP_ADDI);
  assign w_srca      = w_shift ? 2'b10 : 2'b01;
  assign w_srcb      = w_itype ? 2'b10 : 2'b00;
  assign w_cls       = w_rtype_alu                               ? ALU_RTYPE :
                       (OpCode == OP_ANDI)                       ? ALU_AND   :
                       ((OpCode == OP_SLTI) || (OpCode == OP_SLTIU)) ? ALU_SLT :
                                                                   ALU_ADD;

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk         (clk),
    .rst_n       (reset),
    .i_active    ((r_state == ST_IF) || (r_state == ST_MEM)),
    .i_ready     (mem_ready),
    .i_state_chg (w_next != r_state),
    .o_timeout_c (w_timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RST;
      r_cause <= CAUSE_IRQ;
    end else begin
      r_state <= w_next;
      if (w_next == ST_EXC) r_cause <= w_exc_cause;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_exc_cause = CAUSE_IRQ;
    w_end       = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    EPCWrite    = 1'b0;
    MemtoReg    = 2'b00;
    RegDst      = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = PCS_INC;
    ALUOp       = '0;
    Cause       = 2'b00;

    case (r_state)
      ST_RST: w_next = ST_IF;
      ST_IF: begin
        MemRead = 1'b1;
        if (w_timeout) begin
          w_next      = ST_EXC;
          w_exc_cause = CAUSE_TMO;
        end else if (mem_ready) begin
          IRWrite  = 1'b1;
          PCWrite  = 1'b1;
          PCSource = PCS_INC;
          ALUSrcB  = 2'b01;
          w_next   = ST_ID;
        end
      end
      ST_ID: begin
        ALUSrcB = 2'b11;
        ALUOp   = mk_aluop(OpCode[0], ALU_ADD);
        if (w_jal || w_jalr) begin
          RegWrite = 1'b1;
          MemtoReg = 2'b10;
          RegDst   = w_jal ? 2'b10 : 2'b01;
        end
        if (w_beq)                                w_next = ST_EXE_B;
        else if (w_lw || w_sw)                    w_next = ST_EXE_M;
        else if (w_j || w_jal || w_jr || w_jalr)  w_next = ST_EXE_J;
        else if (w_rtype_alu || w_itype)          w_next = ST_EXE_R;
        else begin
          w_next      = ST_EXC;
          w_exc_cause = CAUSE_RSV;
        end
      end
      ST_EXE_R: begin
        ALUSrcA = w_srca;
        ALUSrcB = w_srcb;
        ALUOp   = mk_aluop(OpCode[0], w_cls);
        w_next  = ST_WB_R;
      end
      ST_WB_R: begin
        ALUSrcA  = w_srca;
        ALUSrcB  = w_srcb;
        ALUOp    = mk_aluop(OpCode[0], w_cls);
        MemtoReg = 2'b01;
        RegDst   = w_rtype ? 2'b01 : 2'b00;
        // An overflowing add/sub/addi must not commit its result.
        if (overflow && w_ovf_op) begin
          w_next      = ST_EXC;
          w_exc_cause = CAUSE_OVF;
        end else begin
          RegWrite = 1'b1;
          w_end    = 1'b1;
        end
      end
      ST_EXE_B: begin
        PCWriteCond = 1'b1;
        PCSource    = PCS_BR;
        ALUOp       = mk_aluop(OpCode[0], ALU_SUB);
        w_end       = 1'b1;
      end
      ST_EXE_J: begin
        PCWrite  = 1'b1;
        PCSource = (w_jr || w_jalr) ? PCS_REG : PCS_JMP;
        w_end    = 1'b1;
      end
      ST_EXE_M: w_next = ST_MEM;
      ST_MEM: begin
        IorD = 1'b1;
        if (w_timeout) begin
          w_next      = ST_EXC;
          w_exc_cause = CAUSE_TMO;
        end else begin
          MemRead  = w_lw;
          MemWrite = w_sw;
          if (mem_ready) begin
            if (w_lw) w_next = ST_WB_M;
            else      w_end  = 1'b1;
          end
        end
      end
      ST_WB_M: begin
        RegWrite = 1'b1;
        w_end    = 1'b1;
      end
      ST_EXC: begin
        EPCWrite = 1'b1;
        PCWrite  = 1'b1;
        PCSource = PCS_EXC;
        Cause    = r_cause;
        w_next   = ST_IF;
      end
      default: w_next = ST_RST;
    endcase

    // Interrupts are only taken between instructions.
    if (w_end) begin
      if (w_irq) begin
        w_next      = ST_EXC;
        w_exc_cause = CAUSE_IRQ;
      end else begin
        w_next = ST_IF;
      end
    end
  end

endmodule

// File: tb/tb_mc_controller_hs.sv
// Self-checking bench: each instruction is expanded into its expected cycle
// trace from the controller's behavioural rules and compared cycle by cycle.
module tb_mc_controller_hs;

  localparam int unsigned TMO = 4;
  localparam int K_R = 0, K_I = 1, K_B = 2, K_M = 3, K_J = 4, K_RSV = 5;

  typedef struct packed {
    logic       pcw, pcwc, iord, mr, mw, irw, rw, epcw;
    logic [1:0] m2r, rdst, srca, srcb;
    logic [2:0] pcs;
    logic [3:0] aluop;
    logic [1:0] cause;
  } outs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, overflow, mem_ready, irq;
  logic [5:0] OpCode, Funct;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, EPCWrite;
  logic [1:0] MemtoReg, RegDst, ALUSrcA, ALUSrcB, Cause;
  logic [2:0] PCSource;
  logic [3:0] ALUOp;

  int         n_vec = 0;
  int         n_err = 0;
  logic [5:0] cur_op, cur_fn;
  logic [5:0] ops [16];
  logic [5:0] fns [11];

  mc_controller_hs #(.ALUOP_W(4), .MEM_TIMEOUT(TMO), .IRQ_EN(1)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .overflow(overflow),
    .mem_ready(mem_ready), .irq(irq), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .EPCWrite(EPCWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .Cause(Cause)
  );

  function automatic outs_t zo();
    outs_t o;
    o = '0;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t sample();
    outs_t a;
    a.pcw = PCWrite;   a.pcwc = PCWriteCond; a.iord = IorD;     a.mr = MemRead;
    a.mw = MemWrite;   a.irw = IRWrite;      a.rw = RegWrite;   a.epcw = EPCWrite;
    a.m2r = MemtoReg;  a.rdst = RegDst;      a.srca = ALUSrcA;  a.srcb = ALUSrcB;
    a.pcs = PCSource;  a.aluop = ALUOp;      a.cause = Cause;
    return a;
  endfunction

  task automatic check(input outs_t e, input string tag);
    outs_t a;
    a = sample();
    n_vec++;
    assert (a === e) else begin
      n_err++;
      $error("FAIL %s op=%h fn=%h: observed %h expected %h", tag, cur_op, cur_fn, a, e);
    end
  endtask

  task automatic cyc(input logic mr, input logic ov, input logic iq, input outs_t e,
                     input string tag);
    @(negedge clk);
    OpCode = cur_op; Funct = cur_fn;
    mem_ready = mr; overflow = ov; irq = iq;
    #1;
    check(e, tag);
  endtask

  task automatic exc(input logic [1:0] c);
    outs_t e;
    e = zo(); e.epcw = 1'b1; e.pcw = 1'b1; e.pcs = 3'b100; e.cause = c;
    cyc(rb(), rb(), rb(), e, "exc");
  endtask

  task automatic fin(input outs_t e, input string tag, input logic ov, input logic iq);
    cyc(rb(), ov, iq, e, tag);
    if (iq) exc(2'd0);
  endtask

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:                                     return (fn == 6'h08 || fn == 6'h09) ? K_J : K_R;
      6'h02, 6'h03:                              return K_J;
      6'h04:                                     return K_B;
      6'h23, 6'h2b:                              return K_M;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f:  return K_I;
      default:                                   return K_RSV;
    endcase
  endfunction

  // Expected trace of one instruction, from fetch through any exception entry.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int if_w,
                          input int mem_w, input logic ovf, input logic iq_end);
    outs_t      e;
    int         k;
    logic [2:0] cls;
    logic       jal, jalr, trap;
    cur_op = op; cur_fn = fn;
    k    = kind_of(op, fn);
    jal  = (op == 6'h03);
    jalr = (op == 6'h00) && (fn == 6'h09);
    e = zo(); e.mr = 1'b1;
    if (if_w >= int'(TMO)) begin
      repeat (TMO) cyc(1'b0, rb(), rb(), e, "if_wait");
      cyc(rb(), rb(), rb(), e, "if_timeout");
      exc(2'd2);
      return;
    end
    repeat (if_w) cyc(1'b0, rb(), rb(), e, "if_wait");
    e.irw = 1'b1; e.pcw = 1'b1; e.srcb = 2'b01;
    cyc(1'b1, rb(), rb(), e, "if_fetch");
    e = zo(); e.srcb = 2'b11; e.aluop = {op[0], 3'b000};
    if (jal || jalr) begin
      e.rw = 1'b1; e.m2r = 2'b10; e.rdst = jal ? 2'b10 : 2'b01;
    end
    cyc(rb(), rb(), rb(), e, "id");
    case (k)
      K_RSV: exc(2'd3);
      K_B: begin
        e = zo(); e.pcwc = 1'b1; e.pcs = 3'b001; e.aluop = {op[0], 3'b001};
        fin(e, "exe_b", rb(), iq_end);
      end
      K_J: begin
        e = zo(); e.pcw = 1'b1; e.pcs = (op == 6'h00) ? 3'b011 : 3'b010;
        fin(e, "exe_j", rb(), iq_end);
      end
      K_R, K_I: begin
        e = zo();
        e.srca = (k == K_R && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) ? 2'b10 : 2'b01;
        e.srcb = (k == K_I) ? 2'b10 : 2'b00;
        cls = (k == K_R) ? 3'b010 : (op == 6'h0c) ? 3'b100 :
              (op == 6'h0a || op == 6'h0b) ? 3'b101 : 3'b000;
        e.aluop = {op[0], cls};
        cyc(rb(), rb(), rb(), e, "exe_r");
        e.rw = 1'b1; e.m2r = 2'b01; e.rdst = (k == K_R) ? 2'b01 : 2'b00;
        trap = ovf && ((k == K_R && (fn == 6'h20 || fn == 6'h22)) || op == 6'h08);
        if (trap) begin
          e.rw = 1'b0;
          cyc(rb(), 1'b1, rb(), e, "wb_r_ovf");
          exc(2'd1);
        end else begin
          fin(e, "wb_r", ovf, iq_end);
        end
      end
      default: begin
        e = zo();
        cyc(rb(), rb(), rb(), e, "exe_m");
        e.iord = 1'b1;
        if (op == 6'h23) e.mr = 1'b1; else e.mw = 1'b1;
        if (mem_w >= int'(TMO)) begin
          repeat (TMO) cyc(1'b0, rb(), rb(), e, "mem_wait");
          e.mr = 1'b0; e.mw = 1'b0;
          cyc(rb(), rb(), rb(), e, "mem_timeout");
          exc(2'd2);
        end else begin
          repeat (mem_w) cyc(1'b0, rb(), rb(), e, "mem_wait");
          if (op == 6'h23) begin
            cyc(1'b1, rb(), rb(), e, "mem_done_lw");
            e = zo(); e.rw = 1'b1;
            fin(e, "wb_m", rb(), iq_end);
          end else begin
            cyc(1'b1, rb(), iq_end, e, "mem_done_sw");
            if (iq_end) exc(2'd0);
          end
        end
      end
    endcase
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 9));
    return (r < 7) ? (r % 3) : (r - 3);
  endfunction

  initial begin
    outs_t e;
    int    r;
    ops = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09,
            6'h0a, 6'h0b, 6'h0c, 6'h0f, 6'h23, 6'h2b, 6'h3f, 6'h10};
    fns = '{6'h20, 6'h22, 6'h21, 6'h24, 6'h2a, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h25};
    reset = 1'b0; OpCode = '0; Funct = '0; overflow = 1'b0; mem_ready = 1'b0; irq = 1'b0;
    cur_op = '0; cur_fn = '0;

    repeat (2) cyc(rb(), rb(), rb(), zo(), "reset_hold");
    @(negedge clk); reset = 1'b1; #1;
    check(zo(), "rst_state");

    do_instr(6'h00, 6'h20, 3, 0, 1'b0, 1'b0);   // add, three fetch wait cycles
    do_instr(6'h00, 6'h20, 0, 0, 1'b1, 1'b0);   // add overflow trap
    do_instr(6'h23, 6'h00, 0, 5, 1'b0, 1'b0);   // lw stuck, bus timeout
    do_instr(6'h03, 6'h00, 1, 0, 1'b0, 1'b1);   // jal with irq at end
    do_instr(6'h3f, 6'h00, 0, 0, 1'b0, 1'b0);   // reserved opcode
    do_instr(6'h08, 6'h00, 0, 0, 1'b1, 1'b1);   // addi overflow beats irq
    do_instr(6'h04, 6'h00, 0, 0, 1'b0, 1'b0);   // beq
    do_instr(6'h2b, 6'h00, 0, 3, 1'b0, 1'b1);   // sw, max non-timeout wait, irq

    // Asynchronous reset in the middle of a store
    cur_op = 6'h2b; cur_fn = 6'h00;
    e = zo(); e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; e.srcb = 2'b01;
    cyc(1'b1, 1'b0, 1'b0, e, "sw_if");
    e = zo(); e.srcb = 2'b11; e.aluop = 4'b1000;
    cyc(1'b0, 1'b0, 1'b0, e, "sw_id");
    cyc(1'b0, 1'b0, 1'b0, zo(), "sw_exe_m");
    e = zo(); e.iord = 1'b1; e.mw = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, e, "sw_mem_wait");
    #2 reset = 1'b0;
    #1 check(zo(), "rst_async");
    cyc(1'b1, 1'b0, 1'b1, zo(), "rst_held");
    @(negedge clk); reset = 1'b1; #1;
    check(zo(), "rst_release");
    do_instr(6'h23, 6'h00, 0, 3, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 15));
      do_instr(ops[r], (ops[r] == 6'h00) ? fns[$urandom_range(0, 10)] : 6'($urandom),
               rand_wait(), rand_wait(), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_controller_hs.md
MC_CONTROLLER_HS -- requirements
Module: mc_controller_hs

Interface
REQ-001 Parameter ALUOP_W, default 4: ALUOp width; must be 4 or more; bit [ALUOP_W-1] = OpCode[0], bits [2:0] = class code, other bits 0.
REQ-002 Parameter MEM_TIMEOUT, default 0: maximum wait cycles for mem_ready; 0 disables the timeout.
REQ-003 Parameter IRQ_EN, default 1: 1 enables the irq input; 0 ties irq internally to 0.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 OpCode / Funct  in  6 each  fields of the instruction register.
REQ-007 overflow  in  1  ALU signed overflow of the current operation.
REQ-008 mem_ready  in  1  memory completes the requested read or write this cycle.
REQ-009 irq  in  1  level interrupt request.
REQ-010 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, EPCWrite  out  1 each  datapath enables.
REQ-011 MemtoReg, RegDst, ALUSrcA, ALUSrcB  out  2 each  datapath mux selects.
REQ-012 PCSource  out  3  PC mux select: 000 = PC+4, 001 = branch, 010 = jump, 011 = register, 100 = exception vector.
REQ-013 ALUOp  out  ALUOP_W  ALU class code.
REQ-014 Cause  out  2  exception cause, valid while EPCWrite=1: 0 = irq, 1 = overflow, 2 = bus timeout, 3 = reserved instruction.

Function
REQ-015 States: RST, IF, ID, EXE_R, EXE_B, EXE_J, EXE_M, MEM, WB_R, WB_M, EXC.
REQ-016 Transitions:
- RST -> IF.
- ID -> EXE_B for beq (04).
- ID -> EXE_M for lw (23) or sw (2b).
- ID -> EXE_J for j (02), jal (03), jr (00/08) or jalr (00/09).
- ID -> EXE_R for other R-type or ALU-immediate codes (08, 09, 0a, 0b, 0c, 0f).
- ID -> EXC with Cause 3 for any other opcode.
REQ-017 Further transitions:
- EXE_R -> WB_R.
- EXE_M -> MEM.
- MEM -> WB_M for lw; MEM -> instruction end for sw.
- EXE_B, EXE_J, WB_R, WB_M -> instruction end.
- EXC -> IF.
REQ-018 Instruction end: next state is EXC with Cause 0 if irq=1 (IRQ_EN=1); otherwise IF.
REQ-019 IF: MemRead=1 and IorD=0 in every cycle; IRWrite=1 and PCWrite=1 (PCSource=000, ALUSrcA=00, ALUSrcB=01) only in the cycle where mem_ready=1; stays in IF while mem_ready=0.
REQ-020 MEM: IorD=1 in every cycle; MemRead=1 for lw or MemWrite=1 for sw, held until mem_ready=1; leaves MEM only in the mem_ready cycle.
REQ-021 Wait counter: counts consecutive cycles with mem_ready=0 in IF or MEM; clears on mem_ready=1 and on any state change.
REQ-022 Timeout: if MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT, next state is EXC with Cause 2; MemWrite is deasserted from that cycle on.
REQ-023 ID: ALUSrcA=00, ALUSrcB=11, ALUOp class 000; for jal or jalr also RegWrite=1 and MemtoReg=10; RegDst=10 for jal, 01 for jalr.
REQ-024 EXE_B: PCWriteCond=1, PCSource=001, ALUOp class 001.
REQ-025 EXE_J: PCWrite=1; PCSource=010 for j/jal, 011 for jr/jalr.
REQ-026 EXE_R / WB_R selects:
- ALUSrcA = 10 for sll, srl, sra (funct 00, 02, 03); 01 otherwise.
- ALUSrcB = 10 for I-type; 00 otherwise.
- ALUOp class: 010 for R-type, 100 for andi, 101 for slti/sltiu, 000 otherwise.
REQ-027 WB_R: RegWrite=1, MemtoReg=01, RegDst=01 for R-type and 00 for I-type.
REQ-028 WB_R overflow: if overflow=1 for add (00/20), sub (00/22) or addi (08), RegWrite=0 and next state is EXC with Cause 1.
REQ-029 WB_M: RegWrite=1, MemtoReg=00, RegDst=00.
REQ-030 EXC: EPCWrite=1, PCWrite=1, PCSource=100, Cause driven from a register loaded on entry; exactly one cycle long.
REQ-031 Priority when several causes apply in one cycle: timeout > overflow > reserved instruction > irq.
REQ-032 All outputs not listed for a state are 0.

Reset
REQ-033 reset=0 forces state RST, clears the wait counter and Cause, and drives all outputs to 0, asynchronously and regardless of any transfer in progress.
REQ-034 Leaving reset: one cycle in RST, then IF.

Structure
REQ-035 Shared package mc_pkg holds the state encoding, Cause codes, OpCode/Funct constants, ALUOp class codes and PCSource codes.
REQ-036 Wait counter and timeout compare are one sub-module, mc_wait_timer, parametrised by MEM_TIMEOUT.

Verification
REQ-037 add with mem_ready held low 3 cycles in IF -> MemRead=1 for 4 IF cycles; IRWrite=1 only in the 4th; IF/ID/EXE_R/WB_R sequence follows.
REQ-038 add with overflow=1 in WB_R -> RegWrite=0; next cycle EPCWrite=1, Cause=1, PCSource=100; then IF.
REQ-039 MEM_TIMEOUT=4, lw with mem_ready stuck at 0 -> EXC with Cause=2 after 4 MEM wait cycles; MemRead drops.
REQ-040 irq=1 during EXE_J of jal -> jal PC and $ra updates complete; next state EXC with Cause=0; IF is skipped.
REQ-041 OpCode 3f -> EXC with Cause=3 directly after ID.
REQ-042 reset=0 asserted mid-MEM of sw -> MemWrite=0 immediately; after release, RST then IF.
